// File: rtl/io_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// io_cfg_sequencer
//
// Holds the configuration word of every bidirectional pad cell. Updates arrive
// one pad at a time over a valid/ready request port. An update that turns a
// pad's output driver on first parks the pad in hi-Z and holds it there for
// GUARD_CYCLES. This keeps the pad from switching directly between two driven
// configurations.
//
// Ports:
//   clk             single clock, all state on the rising edge
//   rst             synchronous reset, active-high
//   req_valid       update request valid
//   req_ready       block can accept a request (state IDLE and not in reset)
//   req_pad_idx     target pad index
//   req_cfg         new cfg word for the target pad (bit0: 1 = input/hi-Z)
//   io_cell_cfg_out cfg of pad i at [i*CONF_WIDTH +: CONF_WIDTH]
//   busy            a request is being processed
//   done            one-cycle pulse when a request completes
//   err             one-cycle pulse with done for a rejected request
// -----------------------------------------------------------------------------
module io_cfg_sequencer #(
  parameter int NUM_PADS     = 8,
  parameter int CONF_WIDTH   = 3,
  parameter int GUARD_CYCLES = 4,
  parameter int IDX_W        = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [IDX_W-1:0]               req_pad_idx,
  input  logic [CONF_WIDTH-1:0]          req_cfg,
  output logic [NUM_PADS*CONF_WIDTH-1:0] io_cell_cfg_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESP  = 3'd1,
    S_HIZ   = 3'd2,
    S_GUARD = 3'd3,
    S_APPLY = 3'd4
  } state_t;

  localparam logic [CONF_WIDTH-1:0] CFG_RESET  = CONF_WIDTH'(1);
  localparam logic [7:0]            GUARD_LOAD = 8'(GUARD_CYCLES);

  state_t                  state_r;
  state_t                  state_s;
  logic [CONF_WIDTH-1:0]   cfg_r [NUM_PADS];
  logic [IDX_W-1:0]        idx_r;
  logic [CONF_WIDTH-1:0]   new_r;
  logic [CONF_WIDTH-1:0]   hiz_r;
  logic [7:0]              cnt_r;
  logic [7:0]              cnt_s;
  logic                    done_r;
  logic                    err_r;
  logic                    busy_r;
  logic                    done_s;
  logic                    err_s;
  logic                    wr_en_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic [CONF_WIDTH-1:0]   wr_data_s;
  logic [CONF_WIDTH-1:0]   cur_s;
  logic                    idx_ok_s;
  logic                    accept_s;

  assign req_ready = (state_r == S_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  // Widened compare so the range check stays meaningful when NUM_PADS is a power of two.
  assign idx_ok_s = ({1'b0, req_pad_idx} < (IDX_W + 1)'(NUM_PADS));

  // Current cfg of the requested pad, AND-OR mux that avoids indexing past NUM_PADS.
  always_comb begin
    cur_s = CONF_WIDTH'(0);
    for (int i = 0; i < NUM_PADS; i++) begin
      cur_s = cur_s | (cfg_r[i] & {CONF_WIDTH{req_pad_idx == IDX_W'(i)}});
    end
  end

  // Next-state, pad write and response logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_r;
    wr_data_s = new_r;
    case (state_r)
      S_IDLE: begin
        wr_idx_s  = req_pad_idx;
        wr_data_s = req_cfg;
        if (accept_s) begin
          if (!idx_ok_s) begin
            state_s = S_RESP;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else if (req_cfg == cur_s) begin
            state_s = S_RESP;
            done_s  = 1'b1;
          end else if (req_cfg[0]) begin
            state_s = S_RESP;
            done_s  = 1'b1;
            wr_en_s = 1'b1;
          end else begin
            state_s = S_HIZ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      S_HIZ: begin
        // Park the pad in hi-Z and start the guard interval.
        wr_en_s   = 1'b1;
        wr_data_s = hiz_r;
        cnt_s     = GUARD_LOAD;
        state_s   = S_GUARD;
      end
      S_GUARD: begin
        if (cnt_r == 8'd0) begin
          state_s   = S_APPLY;
          wr_en_s   = 1'b1;
          wr_data_s = new_r;
          done_s    = 1'b1;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      S_APPLY: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state, guard counter, request latches and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      idx_r   <= IDX_W'(0);
      new_r   <= CFG_RESET;
      hiz_r   <= CFG_RESET;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= (state_s != S_IDLE);
      if (accept_s) begin
        idx_r <= req_pad_idx;
        new_r <= req_cfg;
        // Same upper bits as the current cfg, direction forced to input.
        hiz_r <= cur_s | CONF_WIDTH'(1);
      end
    end
  end

  // Pad cfg storage; only the addressed pad is ever written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PADS; i++) begin
      if (rst) begin
        cfg_r[i] <= CFG_RESET;
      end else if (wr_en_s && (wr_idx_s == IDX_W'(i))) begin
        cfg_r[i] <= wr_data_s;
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_out
    assign io_cell_cfg_out[g*CONF_WIDTH +: CONF_WIDTH] = cfg_r[g];
  end

endmodule

// File: tb/tb_io_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_io_cfg_sequencer
//
// Two instances: dut_a (8 pads, guard 4) and dut_b (6 pads, guard 0).
// Stimulus pushes the expected {err, full cfg vector} into a per-instance
// queue; monitors pop and compare whenever done pulses. Pad-level timing of
// the hi-Z interval and handshake is checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_io_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid_a = 1'b0;
  logic        req_ready_a;
  logic [2:0]  req_pad_idx_a = 3'd0;
  logic [2:0]  req_cfg_a = 3'd0;
  logic [23:0] cfg_a;
  logic        busy_a, done_a, err_a;

  logic        req_valid_b = 1'b0;
  logic        req_ready_b;
  logic [2:0]  req_pad_idx_b = 3'd0;
  logic [2:0]  req_cfg_b = 3'd0;
  logic [17:0] cfg_b;
  logic        busy_b, done_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  m_a [8];
  logic [2:0]  m_b [6];
  logic [24:0] q_a [$];
  logic [18:0] q_b [$];

  always #5 clk = ~clk;

  io_cfg_sequencer #(.NUM_PADS(8), .CONF_WIDTH(3), .GUARD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_pad_idx(req_pad_idx_a), .req_cfg(req_cfg_a), .io_cell_cfg_out(cfg_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  io_cfg_sequencer #(.NUM_PADS(6), .CONF_WIDTH(3), .GUARD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_pad_idx(req_pad_idx_b), .req_cfg(req_cfg_b), .io_cell_cfg_out(cfg_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pack_a();
    logic [23:0] v;
    for (int i = 0; i < 8; i++) v[i*3 +: 3] = m_a[i];
    return v;
  endfunction

  function automatic logic [17:0] pack_b();
    logic [17:0] v;
    for (int i = 0; i < 6; i++) v[i*3 +: 3] = m_b[i];
    return v;
  endfunction

  function automatic logic [2:0] pad_a(input int p);
    return cfg_a[p*3 +: 3];
  endfunction

  function automatic logic [2:0] pad_b(input int p);
    return cfg_b[p*3 +: 3];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_a[i] = 3'b001;
    for (int i = 0; i < 6; i++) m_b[i] = 3'b001;
  endtask

  // Returns 1 ns after the accept edge (T0).
  task automatic send_a(input logic [2:0] idx, input logic [2:0] c, input logic exp_err,
                        input logic expect_done);
    int n;
    if (expect_done) begin
      if (!exp_err) m_a[idx] = c;
      q_a.push_back({exp_err, pack_a()});
    end
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_pad_idx_a = idx; req_cfg_a = c;
    n = 0;
    @(negedge clk);
    while (!req_ready_a && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ready_a_timeout", 32'(req_ready_a), 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] idx, input logic [2:0] c, input logic exp_err);
    int n;
    if (!exp_err) m_b[idx] = c;
    q_b.push_back({exp_err, pack_b()});
    @(posedge clk); #1;
    req_valid_b = 1'b1; req_pad_idx_b = idx; req_cfg_b = c;
    n = 0;
    @(negedge clk);
    while (!req_ready_b && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ready_b_timeout", 32'(req_ready_b), 32'd1);
    @(posedge clk); #1;
    req_valid_b = 1'b0;
  endtask

  // Scoreboard monitor for dut_a.
  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) check("done_a_unexpected", 32'(done_a), 32'd0);
      else check("resp_a", 32'({err_a, cfg_a}), 32'(q_a.pop_front()));
    end else if (err_a) begin
      check("err_a_without_done", 32'(err_a), 32'd0);
    end
  end

  // Scoreboard monitor for dut_b.
  always @(negedge clk) begin
    if (done_b) begin
      if (q_b.size() == 0) check("done_b_unexpected", 32'(done_b), 32'd0);
      else check("resp_b", 32'({err_b, cfg_b}), 32'(q_b.pop_front()));
    end else if (err_b) begin
      check("err_b_without_done", 32'(err_b), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset held 3+ cycles with a request pending.
    rst = 1'b1;
    req_valid_a = 1'b1; req_pad_idx_a = 3'd2; req_cfg_a = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready_a), 32'd0);
      check("rst_cfg", 32'(cfg_a), 32'h249249);
      check("rst_done", 32'(done_a), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid_a = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready_a), 32'd1);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_cfg_b", 32'(cfg_b), 32'h9249);

    // Direct input update.
    send_a(3'd2, 3'b101, 1'b0, 1'b1);
    @(negedge clk);
    check("direct_pad2", 32'(pad_a(2)), 32'h5);
    check("direct_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    check("direct_busy_end", 32'(busy_a), 32'd0);

    // Guarded enable input->output.
    send_a(3'd5, 3'b010, 1'b0, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("guard_pad5_k%0d", k), 32'(pad_a(5)), (k < 6) ? 32'h1 : 32'h2);
      check($sformatf("guard_ready_k%0d", k), 32'(req_ready_a), 32'd0);
    end
    @(negedge clk);
    check("guard_ready_back", 32'(req_ready_a), 32'd1);
    check("guard_busy_end", 32'(busy_a), 32'd0);

    // Output->output with changed upper bits passes through hi-Z 3'b011.
    send_a(3'd5, 3'b110, 1'b0, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("o2o_pad5_k%0d", k), 32'(pad_a(5)),
            (k == 0) ? 32'h2 : ((k < 6) ? 32'h3 : 32'h6));
    end

    // Same value again: NOP, no hi-Z glitch.
    send_a(3'd5, 3'b110, 1'b0, 1'b1);
    @(negedge clk);
    check("nop_pad5_k0", 32'(pad_a(5)), 32'h6);
    @(negedge clk);
    check("nop_pad5_k1", 32'(pad_a(5)), 32'h6);
    check("nop_busy_k1", 32'(busy_a), 32'd0);

    // Reset in the middle of a guarded sequence: no done, all pads reset.
    send_a(3'd3, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cfg", 32'(cfg_a), 32'h249249);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_ready", 32'(req_ready_a), 32'd1);
    send_a(3'd3, 3'b000, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("fresh_pad3", 32'(pad_a(3)), 32'h0);

    // dut_b: rejects at and beyond NUM_PADS, direct on the last pad.
    send_b(3'd7, 3'b000, 1'b1);
    send_b(3'd6, 3'b101, 1'b1);
    send_b(3'd5, 3'b111, 1'b0);
    // Zero guard: hi-Z at T0+1, new value at T0+2.
    send_b(3'd0, 3'b010, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("g0a_pad0_k1", 32'(pad_b(0)), 32'h1);
    @(negedge clk);
    check("g0a_pad0_k2", 32'(pad_b(0)), 32'h2);
    send_b(3'd0, 3'b000, 1'b0);
    @(negedge clk);
    check("g0b_pad0_k0", 32'(pad_b(0)), 32'h2);
    @(negedge clk);
    check("g0b_pad0_k1", 32'(pad_b(0)), 32'h3);
    @(negedge clk);
    check("g0b_pad0_k2", 32'(pad_b(0)), 32'h0);
    check("g0b_busy_k2", 32'(busy_b), 32'd1);

    repeat (4) @(negedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
